ysyx_24080006_axi_arbiter: RTL and testbench



---
 rtl/ysyx_24080006_axi_arbiter_if.sv | 49 ++++
 rtl/ysyx_24080006_axi_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_ysyx_24080006_axi_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24080006_axi_arbiter_if.sv
// AXI4 bundle shared by the core-side requesters and the arbiter.
// 32-bit address/data, 4-bit IDs.
interface ysyx_24080006_axi;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arid, arlen, arsize, arburst, arvalid, input arready,
        input rdata, rresp, rlast, rid, rvalid, output rready,
        output awaddr, awid, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bresp, bid, bvalid, output bready
    );

    modport slave (
        input araddr, arid, arlen, arsize, arburst, arvalid, output arready,
        output rdata, rresp, rlast, rid, rvalid, input rready,
        input awaddr, awid, awlen, awsize, awburst, awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bresp, bid, bvalid, input bready
    );
endinterface

// File: rtl/ysyx_24080006_axi_arbiter.sv
// Two-requester AXI4 arbiter: IFU (read bursts) and LSU (single-beat read/write)
// share one downstream master port, one transaction in flight at a time.
module ysyx_24080006_axi_arbiter_chk (
    input logic clock,
    input logic reset,
    input logic i_ifu_awvalid
);
    // The IFU is read-only; a write request from it is a wiring bug upstream
    always @(posedge clock) begin
        if (!reset) begin
            assert (!i_ifu_awvalid);
        end
    end
endmodule

module ysyx_24080006_axi_arbiter #(
    parameter bit LSU_PRIO = 1'b0
) (
    input logic               clock,
    input logic               reset,
    ysyx_24080006_axi.slave   ifu,
    ysyx_24080006_axi.slave   lsu,
    ysyx_24080006_axi.master  axi
);
    typedef enum logic [1:0] {IDLE, RD_IFU, RD_LSU, WR_LSU} state_t;

    state_t r_state;
    logic   r_ar_done;
    logic   r_aw_done;
    logic   r_w_done;
    logic   r_rr_last;

    logic w_lsu_req;
    logic w_pick_lsu;
    logic w_sel_ifu;
    logic w_ar_hs;
    logic w_r_end;
    logic w_aw_hs;
    logic w_w_last_hs;
    logic w_b_hs;
    logic w_unused_ifu;

    assign w_lsu_req   = lsu.arvalid | lsu.awvalid;
    // On a tie the LSU wins when prioritised, or when the IFU had the last grant
    assign w_pick_lsu  = w_lsu_req & (~ifu.arvalid | LSU_PRIO | ~r_rr_last);
    assign w_sel_ifu   = (r_state == RD_IFU);
    assign w_ar_hs     = axi.arvalid & axi.arready;
    assign w_r_end     = axi.rvalid & axi.rready & axi.rlast;
    assign w_aw_hs     = axi.awvalid & axi.awready;
    assign w_w_last_hs = axi.wvalid & axi.wready & axi.wlast;
    assign w_b_hs      = axi.bvalid & axi.bready;

    assign axi.araddr  = w_sel_ifu ? ifu.araddr  : lsu.araddr;
    assign axi.arid    = w_sel_ifu ? ifu.arid    : lsu.arid;
    assign axi.arlen   = w_sel_ifu ? ifu.arlen   : lsu.arlen;
    assign axi.arsize  = w_sel_ifu ? ifu.arsize  : lsu.arsize;
    assign axi.arburst = w_sel_ifu ? ifu.arburst : lsu.arburst;
    assign axi.awaddr  = lsu.awaddr;
    assign axi.awid    = lsu.awid;
    assign axi.awlen   = lsu.awlen;
    assign axi.awsize  = lsu.awsize;
    assign axi.awburst = lsu.awburst;
    assign axi.wdata   = lsu.wdata;
    assign axi.wstrb   = lsu.wstrb;
    assign axi.wlast   = lsu.wlast;

    assign ifu.rdata   = axi.rdata;
    assign ifu.rresp   = axi.rresp;
    assign ifu.rlast   = axi.rlast;
    assign ifu.rid     = axi.rid;
    assign lsu.rdata   = axi.rdata;
    assign lsu.rresp   = axi.rresp;
    assign lsu.rlast   = axi.rlast;
    assign lsu.rid     = axi.rid;
    assign lsu.bresp   = axi.bresp;
    assign lsu.bid     = axi.bid;

    assign ifu.awready = 1'b0;
    assign ifu.wready  = 1'b0;
    assign ifu.bvalid  = 1'b0;
    assign ifu.bresp   = 2'b00;
    assign ifu.bid     = 4'h0;

    assign w_unused_ifu = ^{ifu.awaddr, ifu.awid, ifu.awlen, ifu.awsize, ifu.awburst,
                            ifu.wdata, ifu.wstrb, ifu.wlast, ifu.wvalid, ifu.bready};

    // Handshake steering: only the granted requester sees the downstream port
    always_comb begin
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        ifu.arready = 1'b0;
        ifu.rvalid  = 1'b0;
        lsu.arready = 1'b0;
        lsu.rvalid  = 1'b0;
        lsu.awready = 1'b0;
        lsu.wready  = 1'b0;
        lsu.bvalid  = 1'b0;
        case (r_state)
            RD_IFU: begin
                axi.arvalid = ifu.arvalid & ~r_ar_done;
                ifu.arready = axi.arready & ~r_ar_done;
                ifu.rvalid  = axi.rvalid;
                axi.rready  = ifu.rready;
            end
            RD_LSU: begin
                axi.arvalid = lsu.arvalid & ~r_ar_done;
                lsu.arready = axi.arready & ~r_ar_done;
                lsu.rvalid  = axi.rvalid;
                axi.rready  = lsu.rready;
            end
            WR_LSU: begin
                axi.awvalid = lsu.awvalid & ~r_aw_done;
                lsu.awready = axi.awready & ~r_aw_done;
                axi.wvalid  = lsu.wvalid & ~r_w_done;
                lsu.wready  = axi.wready & ~r_w_done;
                lsu.bvalid  = axi.bvalid;
                axi.bready  = lsu.bready;
            end
            default: ;
        endcase
    end

    // Grant FSM and per-channel completion flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_ar_done <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rr_last <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_lsu) begin
                        r_state   <= lsu.awvalid ? WR_LSU : RD_LSU;
                        r_rr_last <= 1'b1;
                    end else if (ifu.arvalid) begin
                        r_state   <= RD_IFU;
                        r_rr_last <= 1'b0;
                    end else begin
                        r_state   <= IDLE;
                    end
                end
                RD_IFU, RD_LSU: begin
                    if (w_r_end) begin
                        r_state   <= IDLE;
                        r_ar_done <= 1'b0;
                    end else if (w_ar_hs) begin
                        r_ar_done <= 1'b1;
                    end else begin
                        r_ar_done <= r_ar_done;
                    end
                end
                WR_LSU: begin
                    // B may arrive before AW/W are both marked; it still ends the write
                    if (w_b_hs) begin
                        r_state   <= IDLE;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end else begin
                        if (w_aw_hs) begin
                            r_aw_done <= 1'b1;
                        end else begin
                            r_aw_done <= r_aw_done;
                        end
                        if (w_w_last_hs) begin
                            r_w_done <= 1'b1;
                        end else begin
                            r_w_done <= r_w_done;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    ysyx_24080006_axi_arbiter_chk u_chk (
        .clock         (clock),
        .reset         (reset),
        .i_ifu_awvalid (ifu.awvalid)
    );
endmodule

// File: tb/tb_ysyx_24080006_axi_arbiter.sv
// Bench for the IFU/LSU AXI arbiter: round-robin and LSU-priority instances
// driven side by side, with a response scoreboard on the read data paths.
module tb_ysyx_24080006_axi_arbiter;
    localparam logic [31:0] IFU_A  = 32'h8000_0000;
    localparam logic [31:0] LSU_RA = 32'h0200_0000;
    localparam logic [31:0] LSU_WA = 32'h0200_4000;

    typedef struct {
        logic        ifu_ar;
        logic        lsu_ar;
        logic        lsu_aw;
        logic        exp0_arv;
        logic        exp0_awv;
        logic [31:0] exp0_addr;
        logic        exp1_arv;
        logic        exp1_awv;
        logic [31:0] exp1_addr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    vec_t        vecs [8];
    logic [31:0] q_rd [$];
    logic [31:0] q_ar0 [$];
    logic [31:0] q_ar1 [$];

    always #5 clk = ~clk;

    ysyx_24080006_axi ifu0 ();
    ysyx_24080006_axi lsu0 ();
    ysyx_24080006_axi axi0 ();
    ysyx_24080006_axi ifu1 ();
    ysyx_24080006_axi lsu1 ();
    ysyx_24080006_axi axi1 ();

    ysyx_24080006_axi_arbiter #(.LSU_PRIO(1'b0)) dut0 (
        .clock (clk), .reset (rst), .ifu (ifu0), .lsu (lsu0), .axi (axi0)
    );
    ysyx_24080006_axi_arbiter #(.LSU_PRIO(1'b1)) dut1 (
        .clock (clk), .reset (rst), .ifu (ifu1), .lsu (lsu1), .axi (axi1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] outs0();
        return {axi0.arvalid, axi0.awvalid, axi0.wvalid, axi0.rready, axi0.bready,
                ifu0.arready, ifu0.rvalid, ifu0.awready, ifu0.wready, ifu0.bvalid,
                lsu0.arready, lsu0.rvalid, lsu0.awready, lsu0.wready, lsu0.bvalid};
    endfunction

    task automatic clear_drives();
        ifu0.araddr = IFU_A;  ifu0.arid = 4'h1; ifu0.arlen = 8'h00; ifu0.arsize = 3'h2;
        ifu0.arburst = 2'h1;  ifu0.arvalid = 1'b0; ifu0.rready = 1'b0;
        ifu0.awaddr = 32'h0;  ifu0.awid = 4'h0; ifu0.awlen = 8'h00; ifu0.awsize = 3'h0;
        ifu0.awburst = 2'h0;  ifu0.awvalid = 1'b0; ifu0.wdata = 32'h0; ifu0.wstrb = 4'h0;
        ifu0.wlast = 1'b0;    ifu0.wvalid = 1'b0; ifu0.bready = 1'b0;
        lsu0.araddr = LSU_RA; lsu0.arid = 4'h2; lsu0.arlen = 8'h00; lsu0.arsize = 3'h2;
        lsu0.arburst = 2'h1;  lsu0.arvalid = 1'b0; lsu0.rready = 1'b0;
        lsu0.awaddr = LSU_WA; lsu0.awid = 4'h3; lsu0.awlen = 8'h00; lsu0.awsize = 3'h2;
        lsu0.awburst = 2'h1;  lsu0.awvalid = 1'b0; lsu0.wdata = 32'h0; lsu0.wstrb = 4'h0;
        lsu0.wlast = 1'b0;    lsu0.wvalid = 1'b0; lsu0.bready = 1'b0;
        axi0.arready = 1'b0;  axi0.rdata = 32'h0; axi0.rresp = 2'b00; axi0.rlast = 1'b0;
        axi0.rid = 4'h0;      axi0.rvalid = 1'b0; axi0.awready = 1'b0; axi0.wready = 1'b0;
        axi0.bresp = 2'b00;   axi0.bid = 4'h0;  axi0.bvalid = 1'b0;
        ifu1.araddr = IFU_A;  ifu1.arvalid = 1'b0; ifu1.rready = 1'b0; ifu1.awvalid = 1'b0;
        lsu1.araddr = LSU_RA; lsu1.arvalid = 1'b0; lsu1.rready = 1'b0;
        lsu1.awaddr = LSU_WA; lsu1.awvalid = 1'b0; lsu1.wvalid = 1'b0; lsu1.bready = 1'b0;
        axi1.arready = 1'b0;  axi1.rvalid = 1'b0; axi1.rlast = 1'b0;
        axi1.awready = 1'b0;  axi1.wready = 1'b0; axi1.bvalid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_drives();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int  n_gr0;
        int  n_gr1;
        int  n_aw_hs;
        int  n_w_hs;
        int  n_w_hi;
        logic pend0;
        logic pend1;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, IFU_A,  1'b1, 1'b0, IFU_A};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, LSU_RA, 1'b1, 1'b0, LSU_RA};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, IFU_A,  1'b1, 1'b0, LSU_RA};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, IFU_A,  1'b0, 1'b1, 32'h0};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, IFU_A,  1'b0, 1'b1, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0};

        clear_drives();
        #2;
        check("in_reset_outs", {17'h0, outs0()}, 32'h0);
        do_reset();
        #1;
        check("after_reset_outs", {17'h0, outs0()}, 32'h0);

        // Single-shot arbitration from a fresh reset (IFU wins the first tie)
        foreach (vecs[i]) begin
            do_reset();
            @(negedge clk);
            ifu0.arvalid = vecs[i].ifu_ar; lsu0.arvalid = vecs[i].lsu_ar; lsu0.awvalid = vecs[i].lsu_aw;
            ifu1.arvalid = vecs[i].ifu_ar; lsu1.arvalid = vecs[i].lsu_ar; lsu1.awvalid = vecs[i].lsu_aw;
            #1;
            check($sformatf("v%0d_idle", i), {28'h0, axi0.arvalid, axi0.awvalid, axi1.arvalid, axi1.awvalid}, 32'h0);
            @(negedge clk);
            #1;
            check($sformatf("v%0d_d0_valids", i), {30'h0, axi0.arvalid, axi0.awvalid},
                  {30'h0, vecs[i].exp0_arv, vecs[i].exp0_awv});
            check($sformatf("v%0d_d1_valids", i), {30'h0, axi1.arvalid, axi1.awvalid},
                  {30'h0, vecs[i].exp1_arv, vecs[i].exp1_awv});
            if (vecs[i].exp0_arv) check($sformatf("v%0d_d0_addr", i), axi0.araddr, vecs[i].exp0_addr);
            if (vecs[i].exp1_arv) check($sformatf("v%0d_d1_addr", i), axi1.araddr, vecs[i].exp1_addr);
        end

        // Continuous ties: round-robin alternates, LSU_PRIO always picks the LSU
        do_reset();
        q_ar0 = '{IFU_A, LSU_RA, IFU_A, LSU_RA};
        q_ar1 = '{LSU_RA, LSU_RA, LSU_RA, LSU_RA};
        ifu0.arvalid = 1'b1; lsu0.arvalid = 1'b1; ifu0.rready = 1'b1; lsu0.rready = 1'b1;
        ifu1.arvalid = 1'b1; lsu1.arvalid = 1'b1; ifu1.rready = 1'b1; lsu1.rready = 1'b1;
        axi0.arready = 1'b1; axi1.arready = 1'b1;
        pend0 = 1'b0; pend1 = 1'b0; n_gr0 = 0; n_gr1 = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            axi0.rvalid = pend0; axi0.rlast = pend0;
            axi1.rvalid = pend1; axi1.rlast = pend1;
            #1;
            pend0 = axi0.arvalid & axi0.arready;
            pend1 = axi1.arvalid & axi1.arready;
            if (pend0) begin
                n_gr0++;
                if (q_ar0.size() > 0) check($sformatf("rr_grant%0d", n_gr0), axi0.araddr, q_ar0.pop_front());
            end
            if (pend1) begin
                n_gr1++;
                if (q_ar1.size() > 0) check($sformatf("prio_grant%0d", n_gr1), axi1.araddr, q_ar1.pop_front());
            end
        end
        check("rr_grant_count", n_gr0, 32'd4);
        check("prio_grant_count", n_gr1, 32'd4);

        // IFU 4-beat burst, data in order, LSU sees no rvalid, IDLE after rlast
        do_reset();
        @(negedge clk);
        ifu0.arvalid = 1'b1; ifu0.arlen = 8'd3; ifu0.rready = 1'b1;
        #1;
        check("burst_ar_latency", axi0.arvalid, 32'h0);
        @(negedge clk);
        axi0.arready = 1'b1;
        #1;
        check("burst_arvalid", axi0.arvalid, 32'h1);
        check("burst_arlen", axi0.arlen, 32'd3);
        check("burst_araddr", axi0.araddr, IFU_A);
        check("burst_ifu_arready", ifu0.arready, 32'h1);
        @(negedge clk);
        ifu0.arvalid = 1'b0; axi0.arready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (b > 0) @(negedge clk);
            axi0.rvalid = 1'b1; axi0.rdata = 32'h1000_00A0 + 32'(b); axi0.rlast = (b == 3);
            q_rd.push_back(axi0.rdata);
            #1;
            check("burst_lsu_rvalid", lsu0.rvalid, 32'h0);
            if (ifu0.rvalid && ifu0.rready) check($sformatf("burst_rdata%0d", b), ifu0.rdata, q_rd.pop_front());
        end
        @(negedge clk);
        axi0.rvalid = 1'b0; axi0.rlast = 1'b0; lsu0.arvalid = 1'b1;
        #1;
        check("burst_idle_after_rlast", axi0.arvalid, 32'h0);
        check("burst_all_beats", q_rd.size(), 32'h0);
        @(negedge clk);
        #1;
        check("burst_next_grant", {axi0.araddr[31:1], axi0.arvalid}, {LSU_RA[31:1], 1'b1});

        // LSU write: W accepted first, AW two cycles later, B passes through
        do_reset();
        @(negedge clk);
        lsu0.awvalid = 1'b1; lsu0.wvalid = 1'b1; lsu0.wdata = 32'hDEAD_BEEF;
        lsu0.wstrb = 4'hF; lsu0.wlast = 1'b1; lsu0.bready = 1'b1; axi0.wready = 1'b1;
        n_aw_hs = 0; n_w_hs = 0; n_w_hi = 0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            axi0.awready = (c == 3);
            axi0.bvalid  = (c == 4);
            if (c == 5) begin
                lsu0.awvalid = 1'b0; lsu0.wvalid = 1'b0;
            end
            #1;
            if (axi0.awvalid && axi0.awready) n_aw_hs++;
            if (axi0.wvalid && axi0.wready) n_w_hs++;
            if (axi0.wvalid) n_w_hi++;
            if (c == 1) begin
                check("wr_awaddr", axi0.awaddr, LSU_WA);
                check("wr_wdata", axi0.wdata, 32'hDEAD_BEEF);
                check("wr_wstrb", axi0.wstrb, 32'hF);
            end
            if (c == 3) check("wr_lsu_awready", lsu0.awready, 32'h1);
            if (c == 4) begin
                check("wr_aw_gated", axi0.awvalid, 32'h0);
                check("wr_b", {29'h0, lsu0.bvalid, lsu0.bresp}, {29'h0, 1'b1, 2'b00});
            end
        end
        check("wr_aw_handshakes", n_aw_hs, 32'd1);
        check("wr_w_handshakes", n_w_hs, 32'd1);
        check("wr_wvalid_cycles", n_w_hi, 32'd1);

        // Reset during the third beat of an IFU burst drops outputs without a clock edge
        do_reset();
        @(negedge clk);
        ifu0.arvalid = 1'b1; ifu0.arlen = 8'd3; ifu0.rready = 1'b1; axi0.arready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ifu0.arvalid = 1'b0; axi0.arready = 1'b0; axi0.rvalid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre_reset_rpath", {30'h0, ifu0.rvalid, axi0.rready}, 32'h3);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_outs", {17'h0, outs0()}, 32'h0);
        do_reset();

        // LSU read with SLVERR, then an IFU request is granted normally
        @(negedge clk);
        lsu0.arvalid = 1'b1; lsu0.rready = 1'b1; axi0.arready = 1'b1;
        @(negedge clk);
        #1;
        check("lsu_rd_ar", {axi0.araddr[31:1], axi0.arvalid}, {LSU_RA[31:1], 1'b1});
        @(negedge clk);
        lsu0.arvalid = 1'b0; axi0.arready = 1'b0;
        axi0.rvalid = 1'b1; axi0.rlast = 1'b1; axi0.rdata = 32'hCAFE_F00D; axi0.rresp = 2'b10;
        q_rd.push_back(32'hCAFE_F00D);
        #1;
        check("lsu_rd_ifu_rvalid", ifu0.rvalid, 32'h0);
        check("lsu_rd_rresp", lsu0.rresp, 32'h2);
        if (lsu0.rvalid && lsu0.rready) check("lsu_rd_rdata", lsu0.rdata, q_rd.pop_front());
        @(negedge clk);
        axi0.rvalid = 1'b0; axi0.rlast = 1'b0; axi0.rresp = 2'b00; ifu0.arvalid = 1'b1;
        #1;
        check("lsu_rd_idle", axi0.arvalid, 32'h0);
        check("lsu_rd_delivered", q_rd.size(), 32'h0);
        @(negedge clk);
        #1;
        check("ifu_after_slverr", {axi0.araddr[31:1], axi0.arvalid}, {IFU_A[31:1], 1'b1});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
